apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Two-requester APB master that arbitrates round-robin between two local request ports and sequences the winning transfer onto one APB bus (IDLE/SETUP/ACCESS).
- Sits upstream of the APB slave with 5-bit address and 8-bit data.
- Returns read data and slave error to the granted requester.

Parameters:
ADDR_W, 5, APB address width
DATA_W, 8, APB data width
TIMEOUT_CYC, 16, ACCESS wait-cycle limit (used only with APB_TIMEOUT_EN)

Ports:
CLK  in  1  clock; all logic on rising edge
Rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has a transfer pending; held until req0_ack
req0_write  in  1  1=write, 0=read
req0_addr  in  ADDR_W  transfer address
req0_wdata  in  DATA_W  write data
req0_ack  out  1  one-cycle pulse: request captured
req0_done  out  1  one-cycle pulse: transfer finished
req0_rdata  out  DATA_W  read data, valid while req0_done=1
req0_err  out  1  error status, valid while req0_done=1
req1_*  same set as req0_*, for requester 1
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PREADY  in  1  slave ready
PRDATA  in  DATA_W  slave read data
PSLVERR  in  1  slave error

Behaviour:
- Reset: synchronous, active-high. On the edge with Rst=1:
  - state=IDLE; all outputs 0; last_grant=1, so req0 wins the first tie.
  - Any in-flight transfer is dropped; no done pulse is issued for it.
- All outputs are registered.
- FSM IDLE (PSEL=0, PENABLE=0):
  - If any reqN_valid=1, pick the winner, latch its write/addr/wdata into PWRITE/PADDR/PWDATA, pulse reqN_ack, go to SETUP.
  - Otherwise stay in IDLE.
- FSM SETUP (PSEL=1, PENABLE=0): always go to ACCESS on the next edge. PADDR/PWRITE/PWDATA are stable.
- FSM ACCESS (PSEL=1, PENABLE=1): hold all bus outputs while PREADY=0. On the edge where PREADY=1:
  - Pulse reqN_done for the granted requester.
  - reqN_rdata = PRDATA for reads, 0 for writes.
  - reqN_err = PSLVERR.
  - If any reqN_valid=1 (the requester just served may re-request), arbitrate again, latch the new request, pulse its ack and go directly to SETUP (PSEL stays 1, PENABLE=0). Otherwise go to IDLE.
- Arbitration:
  - One valid: that requester wins.
  - Both valid: the requester not equal to last_grant wins.
  - last_grant updates on every grant.
- Latency, uncontended, PREADY tied high:
  - valid sampled at edge t.
  - ack and SETUP from t+1; ACCESS from t+2.
  - done at t+3; next SETUP at t+3 if another request is pending.
- The ack and done pulses for the two requesters are mutually exclusive per cycle. One ack and one done may coincide (back-to-back).
- reqN_rdata and reqN_err hold their last values when done=0. Value outside the done cycle is don't-care.
- A requester that drops valid before ack has its request discarded. No partial APB cycle is ever started.
- Slave wait states are unbounded unless APB_TIMEOUT_EN is defined.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on ACCESS entry and increments on each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYC, on that edge: done pulses with err=1 and rdata=0, PSEL/PENABLE drop to 0, state=IDLE. A late PREADY is ignored.
- Not defined: no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- Write, PREADY tied high: req0 write addr=5'h03 wdata=8'hA5 -> req0_ack at t+1; PSEL=1,PENABLE=0,PADDR=3,PWDATA=A5 at t+1; PENABLE=1 at t+2; req0_done=1, err=0 at t+3.
- Read with waits: req1 read addr=5'h03, slave holds PREADY=0 for 3 ACCESS cycles then returns PRDATA=8'hA5 -> bus fields stable through the waits; req1_done=1, rdata=8'hA5 exactly once.
- Contention: both valid from reset, each re-requesting after its done -> grant order 0,1,0,1; back-to-back transfers go ACCESS->SETUP with no IDLE cycle between them.
- Slave error: PSLVERR=1 with PREADY on a req0 write to 5'h1F -> req0_done=1 with req0_err=1; next transfer has err=0.
- Reset mid-ACCESS: assert Rst for 1 cycle during wait states -> next edge PSEL=PENABLE=0, no done pulse; after release a req1 request is granted normally.
- With APB_TIMEOUT_EN, TIMEOUT_CYC=4, PREADY never asserted -> after 4 ACCESS wait cycles req0_done=1, err=1, rdata=0, PSEL=0, state IDLE.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master: arbitrates, then runs IDLE/SETUP/ACCESS.
// Optional ACCESS wait-state timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              CLK,
  input  logic              Rst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ack,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ack,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state_q;
  logic              lastGrant_q;
  logic              grant_q;
  logic              grant_d;
  logic              anyValid;
  logic              finishOk;
  logic              startXfer;
  logic              timeoutHit;
  logic [DATA_W-1:0] doneRdata;
  logic              doneErr;

`ifdef APB_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] waitCnt_q;

  // Counts ACCESS wait states; zero on the first ACCESS cycle of every transfer.
  always_ff @(posedge CLK) begin
    if (Rst || state_q != ACCESS) begin
      waitCnt_q <= '0;
    end else if (!PREADY) begin
      waitCnt_q <= waitCnt_q + CntW'(1);
    end
  end

  assign timeoutHit = (state_q == ACCESS) && !PREADY && (waitCnt_q == CntLast);
`else
  logic [31:0] unusedTimeoutCyc;
  assign unusedTimeoutCyc = 32'(TIMEOUT_CYC);
  assign timeoutHit       = 1'b0;
`endif

  // Round-robin: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    anyValid  = req0_valid | req1_valid;
    grant_d   = req1_valid;
    if (req0_valid && req1_valid) begin
      grant_d = ~lastGrant_q;
    end
    finishOk  = (state_q == ACCESS) && PREADY;
    startXfer = anyValid && ((state_q == IDLE) || finishOk);
    doneRdata = (PREADY && !PWRITE) ? PRDATA : '0;
    doneErr   = PREADY ? PSLVERR : 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      grant_q     <= 1'b0;
      req0_ack    <= 1'b0;
      req0_done   <= 1'b0;
      req0_rdata  <= '0;
      req0_err    <= 1'b0;
      req1_ack    <= 1'b0;
      req1_done   <= 1'b0;
      req1_rdata  <= '0;
      req1_err    <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
    end else begin
      req0_ack  <= 1'b0;
      req1_ack  <= 1'b0;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      unique case (state_q)
        IDLE: begin
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (PREADY || timeoutHit) begin
            if (grant_q) begin
              req1_done  <= 1'b1;
              req1_rdata <= doneRdata;
              req1_err   <= doneErr;
            end else begin
              req0_done  <= 1'b1;
              req0_rdata <= doneRdata;
              req0_err   <= doneErr;
            end
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // A new grant overrides the return to IDLE, giving ACCESS->SETUP back-to-back.
      if (startXfer) begin
        grant_q     <= grant_d;
        lastGrant_q <= grant_d;
        req0_ack    <= ~grant_d;
        req1_ack    <= grant_d;
        PWRITE      <= grant_d ? req1_write : req0_write;
        PADDR       <= grant_d ? req1_addr  : req0_addr;
        PWDATA      <= grant_d ? req1_wdata : req0_wdata;
        PSEL        <= 1'b1;
        PENABLE     <= 1'b0;
        state_q     <= SETUP;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model (grant rule, memory, error address).
module tb_apb_master_arbiter;

  localparam int ADDR_W      = 5;
  localparam int DATA_W      = 8;
  localparam int TIMEOUT_CYC = 4;

  typedef struct {
    bit                id;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
  } xfer_t;

  logic              CLK = 1'b0;
  logic              Rst;
  logic              req0_valid, req0_write, req0_ack, req0_done, req0_err;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata, req0_rdata;
  logic              req1_valid, req1_write, req1_ack, req1_done, req1_err;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata, req1_rdata;
  logic              PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA, PRDATA;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] slaveMem [32];
  logic [DATA_W-1:0] modelMem [32];

  apb_master_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK(CLK), .Rst(Rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 CLK = ~CLK;

  // Simple APB slave: memory-backed, address 5'h1F always answers with an error.
  assign PRDATA  = slaveMem[PADDR];
  assign PSLVERR = (PADDR == 5'h1F);

  always @(posedge CLK) begin
    if (PSEL && PENABLE && PREADY && PWRITE && PADDR != 5'h1F) begin
      slaveMem[PADDR] <= PWDATA;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      slaveMem[i] <= 8'(i * 37 + 11);
      modelMem[i] = 8'(i * 37 + 11);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepClock();
    @(posedge CLK);
    #1;
  endtask

  task automatic clearReqs();
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    PREADY = 1'b1;
    clearReqs();
    stepClock();
    stepClock();
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_bus: got %0h expected 0", {PSEL, PENABLE, PWRITE, PADDR, PWDATA});
    end
    checks++;
    if ({req0_ack, req0_done, req0_rdata, req0_err, req1_ack, req1_done, req1_rdata, req1_err} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_req: got %0h expected 0",
               {req0_ack, req0_done, req0_rdata, req0_err, req1_ack, req1_done, req1_rdata, req1_err});
    end
    Rst = 1'b0;
  endtask

  task automatic test_write();
    PREADY = 1'b1;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 5'h03; req0_wdata = 8'hA5;
    stepClock();
    checks++;
    if ({req0_ack, req1_ack, PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {5'b10101, 5'h03, 8'hA5}) begin
      failures++;
      $display("[TB] FAIL write_setup: got %0h expected %0h",
               {req0_ack, req1_ack, PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {5'b10101, 5'h03, 8'hA5});
    end
    req0_valid = 1'b0;
    stepClock();
    checks++;
    if ({req0_ack, req0_done, PSEL, PENABLE} !== 4'b0011) begin
      failures++;
      $display("[TB] FAIL write_access: got %b expected 0011", {req0_ack, req0_done, PSEL, PENABLE});
    end
    stepClock();
    checks++;
    if ({req0_done, req0_err, req0_rdata, req1_done, PSEL} !== {2'b10, 8'h00, 2'b00}) begin
      failures++;
      $display("[TB] FAIL write_done: got %0h expected %0h",
               {req0_done, req0_err, req0_rdata, req1_done, PSEL}, {2'b10, 8'h00, 2'b00});
    end
    modelMem[3] = 8'hA5;
    stepClock();
    checks++;
    if (req0_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL write_done_once: got %b expected 0", req0_done);
    end
  endtask

  task automatic test_read_waits();
    int doneCount = 0;
    PREADY = 1'b0;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 5'h03; req1_wdata = 8'h00;
    stepClock();
    checks++;
    if ({req1_ack, req0_ack, PSEL, PENABLE, PWRITE, PADDR} !== {5'b10100, 5'h03}) begin
      failures++;
      $display("[TB] FAIL read_setup: got %0h expected %0h",
               {req1_ack, req0_ack, PSEL, PENABLE, PWRITE, PADDR}, {5'b10100, 5'h03});
    end
    req1_valid = 1'b0;
    stepClock();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) PREADY = 1'b1;
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR, req1_done} !== {3'b110, 5'h03, 1'b0}) begin
        failures++;
        $display("[TB] FAIL read_wait_stable[%0d]: got %0h expected %0h", i,
                 {PSEL, PENABLE, PWRITE, PADDR, req1_done}, {3'b110, 5'h03, 1'b0});
      end
      stepClock();
    end
    checks++;
    if ({req1_done, req1_rdata, req1_err, req0_done} !== {1'b1, 8'hA5, 2'b00}) begin
      failures++;
      $display("[TB] FAIL read_done: got %0h expected %0h",
               {req1_done, req1_rdata, req1_err, req0_done}, {1'b1, 8'hA5, 2'b00});
    end
    for (int i = 0; i < 3; i++) begin
      stepClock();
      if (req1_done) doneCount++;
    end
    checks++;
    if (doneCount != 0) begin
      failures++;
      $display("[TB] FAIL read_done_once: got %0d extra pulses expected 0", doneCount);
    end
  endtask

  task automatic test_contention();
    bit grants[$];
    bit expOrder [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int gapCycles = 0;
    int bothAck   = 0;
    bit started   = 1'b0;
    Rst = 1'b1;
    clearReqs();
    PREADY = 1'b1;
    stepClock();
    Rst = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'h01;
    req1_valid = 1'b1; req1_addr = 5'h02;
    for (int cyc = 0; cyc < 40 && grants.size() < 4; cyc++) begin
      stepClock();
      if (req0_ack && req1_ack) bothAck++;
      if (started && !PSEL) gapCycles++;
      if (req0_done) req0_valid = 1'b1;
      if (req1_done) req1_valid = 1'b1;
      if (req0_ack) begin grants.push_back(1'b0); req0_valid = 1'b0; started = 1'b1; end
      if (req1_ack) begin grants.push_back(1'b1); req1_valid = 1'b0; started = 1'b1; end
    end
    checks++;
    if (grants.size() != 4) begin
      failures++;
      $display("[TB] FAIL contention_grants: got %0d grants expected 4", grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grants[i] !== expOrder[i]) begin
          failures++;
          $display("[TB] FAIL contention_order[%0d]: got %0d expected %0d", i, grants[i], expOrder[i]);
        end
      end
    end
    checks++;
    if (gapCycles != 0 || bothAck != 0) begin
      failures++;
      $display("[TB] FAIL contention_b2b: got idle=%0d dual_ack=%0d expected 0/0", gapCycles, bothAck);
    end
    clearReqs();
    for (int i = 0; i < 10 && PSEL; i++) stepClock();
    stepClock();
  endtask

  task automatic test_slave_error();
    PREADY = 1'b1;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 5'h1F; req0_wdata = 8'h3C;
    stepClock();
    req0_valid = 1'b0;
    stepClock();
    stepClock();
    checks++;
    if ({req0_done, req0_err, req0_rdata} !== {2'b11, 8'h00}) begin
      failures++;
      $display("[TB] FAIL slverr_done: got %0h expected %0h", {req0_done, req0_err, req0_rdata}, {2'b11, 8'h00});
    end
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 5'h07; req0_wdata = 8'h5A;
    stepClock();
    req0_valid = 1'b0;
    stepClock();
    stepClock();
    checks++;
    if ({req0_done, req0_err} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL slverr_clear: got %b expected 10", {req0_done, req0_err});
    end
    modelMem[7] = 8'h5A;
    stepClock();
  endtask

  task automatic test_reset_mid_access();
    int spurious = 0;
    PREADY = 1'b0;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 5'h04;
    stepClock();
    req0_valid = 1'b0;
    stepClock();
    stepClock();
    stepClock();
    Rst = 1'b1;
    stepClock();
    checks++;
    if ({PSEL, PENABLE, req0_done, req1_done, req0_ack, req1_ack} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL midreset_bus: got %b expected 000000",
               {PSEL, PENABLE, req0_done, req1_done, req0_ack, req1_ack});
    end
    Rst = 1'b0;
    PREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepClock();
      if (req0_done || req1_done || PSEL) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      failures++;
      $display("[TB] FAIL midreset_nodone: got %0d active cycles expected 0", spurious);
    end
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 5'h03;
    stepClock();
    checks++;
    if ({req1_ack, req0_ack, PSEL, PENABLE, PADDR} !== {4'b1010, 5'h03}) begin
      failures++;
      $display("[TB] FAIL midreset_regrant: got %0h expected %0h",
               {req1_ack, req0_ack, PSEL, PENABLE, PADDR}, {4'b1010, 5'h03});
    end
    req1_valid = 1'b0;
    stepClock();
    stepClock();
    checks++;
    if ({req1_done, req1_rdata, req1_err} !== {1'b1, modelMem[3], 1'b0}) begin
      failures++;
      $display("[TB] FAIL midreset_done: got %0h expected %0h",
               {req1_done, req1_rdata, req1_err}, {1'b1, modelMem[3], 1'b0});
    end
    stepClock();
  endtask

  task automatic test_wait_limit();
    PREADY = 1'b0;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 5'h05;
    stepClock();
    req0_valid = 1'b0;
    stepClock();
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) begin
      stepClock();
      checks++;
      if ({PSEL, PENABLE, req0_done} !== 3'b110) begin
        failures++;
        $display("[TB] FAIL timeout_wait[%0d]: got %b expected 110", i, {PSEL, PENABLE, req0_done});
      end
    end
    stepClock();
    checks++;
    if ({req0_done, req0_err, req0_rdata, PSEL, PENABLE} !== {2'b11, 8'h00, 2'b00}) begin
      failures++;
      $display("[TB] FAIL timeout_done: got %0h expected %0h",
               {req0_done, req0_err, req0_rdata, PSEL, PENABLE}, {2'b11, 8'h00, 2'b00});
    end
    PREADY = 1'b1;
    stepClock();
    checks++;
    if ({req0_done, req1_done, PSEL} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL timeout_late_ready: got %b expected 000", {req0_done, req1_done, PSEL});
    end
`else
    for (int i = 0; i < 20; i++) begin
      stepClock();
      checks++;
      if ({PSEL, PENABLE, req0_done} !== 3'b110) begin
        failures++;
        $display("[TB] FAIL long_wait[%0d]: got %b expected 110", i, {PSEL, PENABLE, req0_done});
      end
    end
    PREADY = 1'b1;
    stepClock();
    checks++;
    if ({req0_done, req0_rdata, req0_err} !== {1'b1, modelMem[5], 1'b0}) begin
      failures++;
      $display("[TB] FAIL long_wait_done: got %0h expected %0h",
               {req0_done, req0_rdata, req0_err}, {1'b1, modelMem[5], 1'b0});
    end
`endif
    stepClock();
  endtask

  task automatic test_random();
    xfer_t             pend[$];
    xfer_t             exp;
    bit                modelLast = 1'b1;
    bit                sv0, sv1, wasAccess, pselBefore, rdyBefore, expAck, expDone, winner, gotId;
    logic [DATA_W-1:0] expRd, gotRd;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic              ew, expErr, gotErr;
    int                zeroRun = 0;
    Rst = 1'b1;
    clearReqs();
    PREADY = 1'b1;
    stepClock();
    Rst = 1'b0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (cyc >= 600 && pend.size() == 0 && !PSEL) break;
      if (cyc < 600) begin
        if (!req0_valid && $urandom_range(0, 3) == 0) begin
          req0_write = 1'($urandom_range(0, 1)); req0_addr = 5'($urandom_range(0, 31));
          req0_wdata = 8'($urandom); req0_valid = 1'b1;
        end else if (req0_valid && $urandom_range(0, 15) == 0) begin
          req0_valid = 1'b0;
        end
        if (!req1_valid && $urandom_range(0, 3) == 0) begin
          req1_write = 1'($urandom_range(0, 1)); req1_addr = 5'($urandom_range(0, 31));
          req1_wdata = 8'($urandom); req1_valid = 1'b1;
        end else if (req1_valid && $urandom_range(0, 15) == 0) begin
          req1_valid = 1'b0;
        end
      end else begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      wasAccess  = PSEL && PENABLE;
      pselBefore = PSEL;
      PREADY     = (wasAccess && zeroRun >= 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
      rdyBefore  = PREADY;
      sv0        = req0_valid;
      sv1        = req1_valid;
      stepClock();
      zeroRun = (wasAccess && !rdyBefore) ? zeroRun + 1 : 0;
      expDone = wasAccess && rdyBefore;
      expAck  = (sv0 || sv1) && (!pselBefore || expDone);

      checks++;
      if ((req0_done | req1_done) !== expDone || (req0_done & req1_done)) begin
        failures++;
        $display("[TB] FAIL rand_done_pulse @%0d: got %b%b expected any=%b", cyc, req0_done, req1_done, expDone);
      end
      if (req0_done || req1_done) begin
        gotId = req1_done;
        checks++;
        if (pend.size() == 0) begin
          failures++;
          $display("[TB] FAIL rand_done_unexpected @%0d: got done with no transfer expected none", cyc);
        end else begin
          exp    = pend.pop_front();
          expErr = (exp.addr == 5'h1F);
          expRd  = exp.wr ? 8'h00 : modelMem[exp.addr];
          gotRd  = gotId ? req1_rdata : req0_rdata;
          gotErr = gotId ? req1_err : req0_err;
          if (gotId !== exp.id || gotRd !== expRd || gotErr !== expErr) begin
            failures++;
            $display("[TB] FAIL rand_done_data @%0d: got id=%0d rd=%0h err=%b expected id=%0d rd=%0h err=%b",
                     cyc, gotId, gotRd, gotErr, exp.id, expRd, expErr);
          end
          if (exp.wr && !expErr) modelMem[exp.addr] = exp.wd;
        end
      end

      checks++;
      if ((req0_ack | req1_ack) !== expAck || (req0_ack & req1_ack)) begin
        failures++;
        $display("[TB] FAIL rand_ack_pulse @%0d: got %b%b expected any=%b", cyc, req0_ack, req1_ack, expAck);
      end
      if (req0_ack || req1_ack) begin
        winner = (sv0 && sv1) ? ~modelLast : sv1;
        gotId  = req1_ack;
        ea     = winner ? req1_addr  : req0_addr;
        ew     = winner ? req1_write : req0_write;
        ed     = winner ? req1_wdata : req0_wdata;
        checks++;
        if (gotId !== winner || {PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {2'b10, ew, ea, ed}) begin
          failures++;
          $display("[TB] FAIL rand_grant @%0d: got id=%0d bus=%0h expected id=%0d bus=%0h",
                   cyc, gotId, {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, winner, {2'b10, ew, ea, ed});
        end
        modelLast = winner;
        pend.push_back('{winner, ew, ea, ed});
        if (gotId) req1_valid = 1'b0;
        else       req0_valid = 1'b0;
      end
    end
    checks++;
    if (pend.size() != 0 || PSEL) begin
      failures++;
      $display("[TB] FAIL rand_drain: got %0d pending psel=%b expected 0/0", pend.size(), PSEL);
    end
  endtask

  initial begin
    Rst = 1'b1;
    PREADY = 1'b1;
    clearReqs();
    test_reset();
    test_write();
    test_read_waits();
    test_contention();
    test_slave_error();
    test_reset_mid_access();
    test_wait_limit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
